// File: rtl/hart_pkg.sv
// Shared defaults and types for the barrel-style hart scheduler.
package hart_pkg;

  localparam int unsigned NUM_HART_DEF   = 4;
  localparam int unsigned PIPE_DEPTH_DEF = 4;

  typedef logic [NUM_HART_DEF-1:0] hart_sel_t;

  // Index width that stays legal (>=1) for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after the last pointer, wrapping.
module rr_pick
  import hart_pkg::*;
#(
  parameter int unsigned N  = NUM_HART_DEF,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    // Scan last+1 .. last+N so the previous winner has lowest priority.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last) + i) % N;
      if (!any && req[IW'(cand)]) begin
        grant[IW'(cand)] = 1'b1;
        grant_idx        = IW'(cand);
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hart_sched.sv
// Fine-grained multithreading scheduler: one instruction per hart in flight,
// round-robin issue into a PIPE_DEPTH-stage tag pipeline with per-hart flush.
module hart_sched
  import hart_pkg::*;
#(
  parameter int unsigned NUM_HART   = NUM_HART_DEF,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic [NUM_HART-1:0] hart_en,
  input  logic [NUM_HART-1:0] hart_stall,
  input  logic                flush,
  input  logic [NUM_HART-1:0] flush_hart_sel,
  output logic [NUM_HART-1:0] pc_rd_hart_sel,
  output logic [NUM_HART-1:0] rd_hart_sel,
  output logic [NUM_HART-1:0] wr_hart_sel,
  output logic                wb_valid,
  output logic [NUM_HART-1:0] inflight
);

  localparam int unsigned IW   = idx_width(NUM_HART);
  localparam int unsigned SW   = idx_width(PIPE_DEPTH);
  localparam int unsigned LAST = PIPE_DEPTH - 1;

  // Stage tags; sel is kept all-zero whenever valid is 0 so outputs are plain flops.
  logic [PIPE_DEPTH-1:0]               stg_valid, nxt_valid;
  logic [PIPE_DEPTH-1:0][NUM_HART-1:0] stg_sel,   nxt_sel;
  logic [NUM_HART-1:0]                 inflight_q, nxt_inflight;
  logic [IW-1:0]                       last_issued, nxt_last;

  logic [NUM_HART-1:0] eligible;
  logic [NUM_HART-1:0] grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_any;

  // A hart being flushed this cycle must not be reissued on the same edge.
  assign eligible = hart_en & ~hart_stall & ~inflight_q
                  & ~({NUM_HART{flush}} & flush_hart_sel);

  rr_pick #(
    .N  (NUM_HART),
    .IW (IW)
  ) u_rr_pick (
    .req       (eligible),
    .last      (last_issued),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    nxt_valid    = stg_valid;
    nxt_sel      = stg_sel;
    nxt_inflight = inflight_q;
    nxt_last     = last_issued;

    if (advance) begin
      if (stg_valid[LAST]) begin
        nxt_inflight = nxt_inflight & ~stg_sel[LAST];
      end
      nxt_valid = {stg_valid[PIPE_DEPTH-2:0], grant_any};
      nxt_sel   = {stg_sel[PIPE_DEPTH-2:0], grant};
      if (grant_any) begin
        nxt_inflight = nxt_inflight | grant;
        nxt_last     = grant_idx;
      end
    end

    // Kill is applied to post-shift positions.
    if (flush) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        if ((nxt_sel[SW'(k)] & flush_hart_sel) != '0) begin
          nxt_valid[SW'(k)] = 1'b0;
          nxt_sel[SW'(k)]   = '0;
        end
      end
      nxt_inflight = nxt_inflight & ~flush_hart_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid   <= '0;
      stg_sel     <= '0;
      inflight_q  <= '0;
      last_issued <= IW'(NUM_HART - 1);
    end else begin
      stg_valid   <= nxt_valid;
      stg_sel     <= nxt_sel;
      inflight_q  <= nxt_inflight;
      last_issued <= nxt_last;
    end
  end

  assign pc_rd_hart_sel = stg_sel[0];
  assign rd_hart_sel    = stg_sel[1];
  assign wr_hart_sel    = stg_sel[LAST];
  assign wb_valid       = stg_valid[LAST];
  assign inflight       = inflight_q;

endmodule

// File: tb/tb_hart_sched.sv
// Directed self-checking bench for hart_sched (4 harts, 4 stages).
module tb_hart_sched;
  import hart_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      advance;
  hart_sel_t hart_en;
  hart_sel_t hart_stall;
  logic      flush;
  hart_sel_t flush_hart_sel;
  hart_sel_t pc_rd_hart_sel;
  hart_sel_t rd_hart_sel;
  hart_sel_t wr_hart_sel;
  logic      wb_valid;
  hart_sel_t inflight;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  hart_sched #(
    .NUM_HART   (4),
    .PIPE_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance),
    .hart_en        (hart_en),
    .hart_stall     (hart_stall),
    .flush          (flush),
    .flush_hart_sel (flush_hart_sel),
    .pc_rd_hart_sel (pc_rd_hart_sel),
    .rd_hart_sel    (rd_hart_sel),
    .wr_hart_sel    (wr_hart_sel),
    .wb_valid       (wb_valid),
    .inflight       (inflight)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; advance = 1'b0; hart_en = '0; hart_stall = '0;
    flush = 1'b0; flush_hart_sel = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight} !== 17'h0) begin
      miss_cnt++;
      $display("FAIL reset_outputs got pc=%b rd=%b wr=%b wbv=%b inf=%b want all zero",
               pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight);
    end
  endtask

  task automatic test_full_rr();
    hart_sel_t exp_pc  [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    hart_sel_t exp_rd  [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    hart_sel_t exp_wr  [10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};
    hart_sel_t exp_inf [10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hE};
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== exp_pc[c] || rd_hart_sel !== exp_rd[c] ||
          wr_hart_sel !== exp_wr[c] || wb_valid !== (exp_wr[c] != 4'h0) ||
          inflight !== exp_inf[c]) begin
        miss_cnt++;
        $display("FAIL full_rr cyc%0d got pc=%b rd=%b wr=%b wbv=%b inf=%b want pc=%b rd=%b wr=%b inf=%b",
                 c, pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight,
                 exp_pc[c], exp_rd[c], exp_wr[c], exp_inf[c]);
      end
    end
  endtask

  task automatic test_sparse();
    hart_sel_t exp_pc  [10] = '{4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0};
    hart_sel_t exp_inf [10] = '{4'h1, 4'h5, 4'h5, 4'h5, 4'h4, 4'h1, 4'h5, 4'h5, 4'h5, 4'h4};
    do_reset();
    hart_en = 4'b0101; advance = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== exp_pc[c] || inflight !== exp_inf[c]) begin
        miss_cnt++;
        $display("FAIL sparse cyc%0d got pc=%b inf=%b want pc=%b inf=%b",
                 c, pc_rd_hart_sel, inflight, exp_pc[c], exp_inf[c]);
      end
    end
  endtask

  task automatic test_hold();
    hart_sel_t exp_pc  [3] = '{4'h2, 4'h4, 4'h8};
    hart_sel_t exp_inf [3] = '{4'hB, 4'h7, 4'hF};
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    for (int c = 0; c < 6; c++) step();
    advance = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== 4'h1 || rd_hart_sel !== 4'h0 || wr_hart_sel !== 4'h4 ||
          wb_valid !== 1'b1 || inflight !== 4'hD) begin
        miss_cnt++;
        $display("FAIL hold cyc%0d got pc=%b rd=%b wr=%b wbv=%b inf=%b want pc=0001 rd=0000 wr=0100 wbv=1 inf=1101",
                 c, pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight);
      end
    end
    advance = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== exp_pc[c] || inflight !== exp_inf[c]) begin
        miss_cnt++;
        $display("FAIL hold_resume cyc%0d got pc=%b inf=%b want pc=%b inf=%b",
                 c, pc_rd_hart_sel, inflight, exp_pc[c], exp_inf[c]);
      end
    end
  endtask

  task automatic test_flush_held();
    hart_sel_t exp_pc [3] = '{4'h4, 4'h1, 4'h2};
    hart_sel_t exp_wr [3] = '{4'h2, 4'h0, 4'h8};
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    for (int c = 0; c < 4; c++) step();
    advance = 1'b0; flush = 1'b1; flush_hart_sel = 4'b0100;
    step();
    vec_cnt++;
    if (rd_hart_sel !== 4'h0 || inflight !== 4'hB || pc_rd_hart_sel !== 4'h8 ||
        wr_hart_sel !== 4'h1) begin
      miss_cnt++;
      $display("FAIL flush_held got rd=%b inf=%b pc=%b wr=%b want rd=0000 inf=1011 pc=1000 wr=0001",
               rd_hart_sel, inflight, pc_rd_hart_sel, wr_hart_sel);
    end
    flush = 1'b0; flush_hart_sel = '0; advance = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== exp_pc[c] || wr_hart_sel !== exp_wr[c]) begin
        miss_cnt++;
        $display("FAIL flush_after cyc%0d got pc=%b wr=%b want pc=%b wr=%b",
                 c, pc_rd_hart_sel, wr_hart_sel, exp_pc[c], exp_wr[c]);
      end
    end
  endtask

  task automatic test_flush_advance();
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    step();
    flush = 1'b1; flush_hart_sel = 4'b0001;
    step();
    vec_cnt++;
    if (pc_rd_hart_sel !== 4'h2 || rd_hart_sel !== 4'h0 || inflight !== 4'h2) begin
      miss_cnt++;
      $display("FAIL flush_shift got pc=%b rd=%b inf=%b want pc=0010 rd=0000 inf=0010",
               pc_rd_hart_sel, rd_hart_sel, inflight);
    end
    flush_hart_sel = 4'b0100;
    step();
    vec_cnt++;
    if (pc_rd_hart_sel !== 4'h8 || rd_hart_sel !== 4'h2 || inflight !== 4'hA) begin
      miss_cnt++;
      $display("FAIL flush_noissue got pc=%b rd=%b inf=%b want pc=1000 rd=0010 inf=1010",
               pc_rd_hart_sel, rd_hart_sel, inflight);
    end
    flush = 1'b0; flush_hart_sel = '0;
    step();
    vec_cnt++;
    if (pc_rd_hart_sel !== 4'h1 || rd_hart_sel !== 4'h8 || inflight !== 4'hB) begin
      miss_cnt++;
      $display("FAIL flush_recover got pc=%b rd=%b inf=%b want pc=0001 rd=1000 inf=1011",
               pc_rd_hart_sel, rd_hart_sel, inflight);
    end
  endtask

  task automatic test_stall();
    hart_sel_t exp_pc  [5] = '{4'h1, 4'h0, 4'h4, 4'h8, 4'h2};
    hart_sel_t exp_inf [5] = '{4'hD, 4'h9, 4'h5, 4'hD, 4'hE};
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    step(); step();
    hart_stall = 4'b0010;
    step(); step(); step();
    vec_cnt++;
    if (wr_hart_sel !== 4'h2 || wb_valid !== 1'b1) begin
      miss_cnt++;
      $display("FAIL stall_retire got wr=%b wbv=%b want wr=0010 wbv=1", wr_hart_sel, wb_valid);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 3) hart_stall = '0;
      step();
      vec_cnt++;
      if (pc_rd_hart_sel !== exp_pc[c] || inflight !== exp_inf[c]) begin
        miss_cnt++;
        $display("FAIL stall cyc%0d got pc=%b inf=%b want pc=%b inf=%b",
                 c, pc_rd_hart_sel, inflight, exp_pc[c], exp_inf[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    hart_en = 4'hF; advance = 1'b1;
    step(); step(); step();
    vec_cnt++;
    if (inflight !== 4'h7) begin
      miss_cnt++;
      $display("FAIL midrst_pre got inf=%b want 0111", inflight);
    end
    rst = 1'b1; flush = 1'b1; flush_hart_sel = 4'b0001;
    step();
    vec_cnt++;
    if ({pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight} !== 17'h0) begin
      miss_cnt++;
      $display("FAIL midrst_clear got pc=%b rd=%b wr=%b wbv=%b inf=%b want all zero",
               pc_rd_hart_sel, rd_hart_sel, wr_hart_sel, wb_valid, inflight);
    end
    rst = 1'b0; flush = 1'b0; flush_hart_sel = '0;
    step();
    vec_cnt++;
    if (pc_rd_hart_sel !== 4'h1 || inflight !== 4'h1) begin
      miss_cnt++;
      $display("FAIL midrst_first got pc=%b inf=%b want pc=0001 inf=0001",
               pc_rd_hart_sel, inflight);
    end
  endtask

  initial begin
    test_reset();
    test_full_rr();
    test_sparse();
    test_hold();
    test_flush_held();
    test_flush_advance();
    test_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
